sakebi_fcs_appender: RTL and testbench

SAKEBI_FCS_APPENDER -- requirements
Module: sakebi_fcs_appender

---
 rtl/sakebi_fcs_appender.sv | 174 +++++++++++++++++
 tb/tb_sakebi_fcs_appender.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sakebi_fcs_appender.sv
// sakebi_fcs_appender: appends a CRC-32 FCS (LSB byte first) to a byte stream.
// Optional zero padding to MIN_FRAME_LEN payload bytes when SAKEBI_FCS_PAD_EN is defined.
//
// Ports:
//   i_clk    : clock, all logic on rising edge
//   i_rst_n  : synchronous active-low reset
//   i_data   : upstream payload byte
//   i_valid  : i_data valid
//   i_last   : i_data is the final payload byte
//   o_ready  : byte accepted when i_valid && o_ready
//   o_data   : downstream byte (payload, pad or FCS)
//   o_valid  : o_data valid
//   o_last   : o_data is the final FCS byte
//   i_ready  : downstream accepts when o_valid && i_ready

module sakebi_fcs_appender #(
    parameter int          DATA_WIDTH    = 8,
    parameter logic [31:0] CRC           = 32'h04C11DB7,
    parameter int          MIN_FRAME_LEN = 60
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready
);

    // Only byte streams are supported; the pad counter is 6 bits wide.
    if (DATA_WIDTH != 8 || MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > 63) begin : g_bad_cfg
        $error("sakebi_fcs_appender: unsupported DATA_WIDTH or MIN_FRAME_LEN");
    end

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] POLY_R = bit_rev32(CRC);

    // One reflected CRC step over a whole byte.
    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ POLY_R) : (r >> 1);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_FCS  = 2'd1
`ifdef SAKEBI_FCS_PAD_EN
        ,
        S_PAD  = 2'd2
`endif
    } state_t;

    state_t      state;
    logic [31:0] crc;
    logic [2:0]  fcs_cnt;
    logic [7:0]  fcs_byte;
    logic        out_free;
    logic        accept;

    // Output register may be reloaded when empty or being drained.
    assign out_free = !o_valid || i_ready;
    assign o_ready  = i_rst_n && (state == S_DATA) && out_free;
    assign accept   = i_valid && o_ready;

    always_comb begin
        fcs_byte = 8'h00;
        case (fcs_cnt[1:0])
            2'd0:    fcs_byte = ~crc[7:0];
            2'd1:    fcs_byte = ~crc[15:8];
            2'd2:    fcs_byte = ~crc[23:16];
            default: fcs_byte = ~crc[31:24];
        endcase
    end

`ifdef SAKEBI_FCS_PAD_EN
    localparam logic [5:0] MIN_LEN = 6'(MIN_FRAME_LEN);

    logic [5:0] count;
    logic [5:0] count_inc;

    // Count including the current byte, saturating at the minimum length.
    assign count_inc = (count == MIN_LEN) ? count : count + 6'd1;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_DATA;
            crc     <= 32'hFFFF_FFFF;
            fcs_cnt <= 3'd0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
`ifdef SAKEBI_FCS_PAD_EN
            count   <= 6'd0;
`endif
        end else begin
            case (state)
                S_DATA: begin
                    if (accept) begin
                        o_data  <= i_data;
                        o_valid <= 1'b1;
                        o_last  <= 1'b0;
                        crc     <= crc_byte(crc, i_data);
`ifdef SAKEBI_FCS_PAD_EN
                        count   <= count_inc;
                        if (i_last) begin
                            state <= (count_inc < MIN_LEN) ? S_PAD : S_FCS;
                        end
`else
                        if (i_last) begin
                            state <= S_FCS;
                        end
`endif
                    end else if (out_free) begin
                        o_valid <= 1'b0;
                    end
                end
`ifdef SAKEBI_FCS_PAD_EN
                S_PAD: begin
                    if (out_free) begin
                        o_data  <= '0;
                        o_valid <= 1'b1;
                        o_last  <= 1'b0;
                        crc     <= crc_byte(crc, 8'h00);
                        count   <= count_inc;
                        if (count_inc == MIN_LEN) begin
                            state <= S_FCS;
                        end
                    end
                end
`endif
                S_FCS: begin
                    if (out_free) begin
                        // fcs_cnt==4 means byte 3 has just been handed off.
                        if (fcs_cnt == 3'd4) begin
                            state   <= S_DATA;
                            crc     <= 32'hFFFF_FFFF;
                            fcs_cnt <= 3'd0;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
`ifdef SAKEBI_FCS_PAD_EN
                            count   <= 6'd0;
`endif
                        end else begin
                            o_data  <= fcs_byte;
                            o_valid <= 1'b1;
                            o_last  <= (fcs_cnt == 3'd3);
                            fcs_cnt <= fcs_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= S_DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sakebi_fcs_appender.sv
// tb_sakebi_fcs_appender: randomized self-checking bench for sakebi_fcs_appender.
// Expected beats come from a queue-based frame model with a bitwise MSB-first CRC-32.

module tb_sakebi_fcs_appender;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [8:0] beat_q_t[$];

    localparam int MIN = 60;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_last;
    logic       o_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_last;
    logic       i_ready;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int ready_mode = 0;
    int stall_err = 0;

    beat_q_t    out_q;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_beat  = '0;

    sakebi_fcs_appender dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Downstream ready: 0 = always, 1 = toggle, 2 = random.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = ~i_ready;
                default: i_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Output monitor: record handshaken beats and stall-hold violations.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && {o_valid, o_last, o_data} !== prev_beat)
                stall_err++;
            if (o_valid && i_ready)
                out_q.push_back({o_last, o_data});
            prev_stall = o_valid && !i_ready;
            prev_beat  = {o_valid, o_last, o_data};
        end
    end

    // Standard CRC-32: MSB-first shift register, bytes fed LSB first.
    function automatic logic [31:0] ref_crc(byte_q_t fr);
        logic [31:0] r;
        logic [31:0] res;
        logic        fb;
        r = 32'hFFFF_FFFF;
        foreach (fr[i]) begin
            for (int j = 0; j < 8; j++) begin
                fb = r[31] ^ fr[i][j];
                r  = r << 1;
                if (fb) r = r ^ 32'h04C1_1DB7;
            end
        end
        for (int j = 0; j < 32; j++) res[j] = r[31-j];
        return ~res;
    endfunction

    function automatic beat_q_t model(byte_q_t p);
        byte_q_t     fr;
        beat_q_t     e;
        logic [31:0] f;
        fr = p;
`ifdef SAKEBI_FCS_PAD_EN
        while (fr.size() < MIN) fr.push_back(8'h00);
`endif
        f = ref_crc(fr);
        foreach (fr[i]) e.push_back({1'b0, fr[i]});
        for (int k = 0; k < 4; k++) e.push_back({k == 3, f[8*k +: 8]});
        return e;
    endfunction

    function automatic byte_q_t rand_frame(int len);
        byte_q_t b;
        for (int i = 0; i < len; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    task automatic send_frame(input byte_q_t b, input int bubble_pct,
                              input bit mark_last);
        int i     = 0;
        int guard = 0;
        while (i < b.size() && guard < 5000) begin
            @(posedge i_clk);
            #1;
            if ($urandom_range(99) < bubble_pct) begin
                i_valid = 1'b0;
                i_data  = 8'($urandom);
                i_last  = 1'($urandom);
            end else begin
                i_valid = 1'b1;
                i_data  = b[i];
                i_last  = mark_last && (i == b.size() - 1);
            end
            @(negedge i_clk);
            if (i_valid && o_ready) i++;
            guard++;
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int c = 0;
        while (out_q.size() < n && c < 3000) begin
            @(posedge i_clk);
            c++;
        end
        repeat (6) @(posedge i_clk);
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_cnt++;
        if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_valid);
        else pass_cnt++;
        check_cnt++;
        if (o_data !== 8'h00) $display("FAIL reset_data: got %h want 00", o_data);
        else pass_cnt++;
        check_cnt++;
        if (o_last !== 1'b0) $display("FAIL reset_last: got %b want 0", o_last);
        else pass_cnt++;
        check_cnt++;
        if (o_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", o_ready);
        else pass_cnt++;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_cnt++;
        if (o_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", o_ready);
        else pass_cnt++;
    endtask

    task automatic test_known_vector;
        byte_q_t kv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                        8'h36, 8'h37, 8'h38, 8'h39};
        beat_q_t exp;
        int      n_last = 0;
        ready_mode = 0;
        out_q.delete();
        exp = model(kv);
        send_frame(kv, 0, 1'b1);
        wait_out(exp.size());
        check_cnt++;
        if (out_q.size() != exp.size())
            $display("FAIL known_len: got %0d want %0d", out_q.size(), exp.size());
        else pass_cnt++;
        for (int i = 0; i < exp.size(); i++) begin
            check_cnt++;
            if (i >= out_q.size() || out_q[i] !== exp[i])
                $display("FAIL known_beat[%0d]: got %h want %h", i,
                         (i < out_q.size()) ? out_q[i] : 9'hxxx, exp[i]);
            else pass_cnt++;
        end
        foreach (out_q[i]) if (out_q[i][8]) n_last++;
        check_cnt++;
        if (n_last != 1) $display("FAIL known_last_count: got %0d want 1", n_last);
        else pass_cnt++;
`ifndef SAKEBI_FCS_PAD_EN
        check_cnt++;
        if (out_q.size() < 4 ||
            {out_q[9], out_q[10], out_q[11], out_q[12]} !==
            {9'h026, 9'h039, 9'h0F4, 9'h1CB})
            $display("FAIL known_fcs: got %p want 026 039 0F4 1CB", out_q);
        else pass_cnt++;
`endif
    endtask

    task automatic test_stall_toggle;
        byte_q_t kv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                        8'h36, 8'h37, 8'h38, 8'h39};
        beat_q_t exp;
        ready_mode = 1;
        stall_err  = 0;
        out_q.delete();
        exp = model(kv);
        send_frame(kv, 0, 1'b1);
        wait_out(exp.size());
        check_cnt++;
        if (out_q.size() != exp.size())
            $display("FAIL stall_len: got %0d want %0d", out_q.size(), exp.size());
        else pass_cnt++;
        for (int i = 0; i < exp.size(); i++) begin
            check_cnt++;
            if (i >= out_q.size() || out_q[i] !== exp[i])
                $display("FAIL stall_beat[%0d]: got %h want %h", i,
                         (i < out_q.size()) ? out_q[i] : 9'hxxx, exp[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (stall_err != 0) $display("FAIL stall_hold: got %0d violations want 0", stall_err);
        else pass_cnt++;
        ready_mode = 0;
    endtask

    task automatic test_back_to_back;
        byte_q_t kv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                        8'h36, 8'h37, 8'h38, 8'h39};
        beat_q_t exp;
        beat_q_t one;
        ready_mode = 0;
        out_q.delete();
        one = model(kv);
        exp = {one, one};
        send_frame(kv, 0, 1'b1);
        send_frame(kv, 0, 1'b1);
        wait_out(exp.size());
        check_cnt++;
        if (out_q.size() != exp.size())
            $display("FAIL b2b_len: got %0d want %0d", out_q.size(), exp.size());
        else pass_cnt++;
        for (int i = 0; i < exp.size(); i++) begin
            check_cnt++;
            if (i >= out_q.size() || out_q[i] !== exp[i])
                $display("FAIL b2b_beat[%0d]: got %h want %h", i,
                         (i < out_q.size()) ? out_q[i] : 9'hxxx, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        byte_q_t part = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        byte_q_t kv   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                          8'h36, 8'h37, 8'h38, 8'h39};
        beat_q_t exp;
        int      n_last = 0;
        ready_mode = 0;
        out_q.delete();
        send_frame(part, 0, 1'b0);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check_cnt++;
        if (o_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", o_ready);
        else pass_cnt++;
        @(negedge i_clk);
        check_cnt++;
        if (o_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", o_valid);
        else pass_cnt++;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (8) @(posedge i_clk);
        foreach (out_q[i]) if (out_q[i][8]) n_last++;
        check_cnt++;
        if (n_last != 0 || out_q.size() > 5)
            $display("FAIL midrst_no_fcs: got %0d beats %0d last want <=5 and 0",
                     out_q.size(), n_last);
        else pass_cnt++;
        out_q.delete();
        exp = model(kv);
        send_frame(kv, 0, 1'b1);
        wait_out(exp.size());
        check_cnt++;
        if (out_q.size() != exp.size())
            $display("FAIL midrst_len: got %0d want %0d", out_q.size(), exp.size());
        else pass_cnt++;
        for (int i = 0; i < exp.size(); i++) begin
            check_cnt++;
            if (i >= out_q.size() || out_q[i] !== exp[i])
                $display("FAIL midrst_beat[%0d]: got %h want %h", i,
                         (i < out_q.size()) ? out_q[i] : 9'hxxx, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random;
        beat_q_t exp;
        byte_q_t fr;
        int      bad = 0;
        ready_mode = 2;
        stall_err  = 0;
        out_q.delete();
        for (int f = 0; f < 6; f++) begin
            fr  = rand_frame($urandom_range(1, 70));
            exp = {exp, model(fr)};
            send_frame(fr, 30, 1'b1);
        end
        wait_out(exp.size());
        check_cnt++;
        if (out_q.size() != exp.size())
            $display("FAIL rand_len: got %0d want %0d", out_q.size(), exp.size());
        else pass_cnt++;
        for (int i = 0; i < exp.size(); i++)
            if (i >= out_q.size() || out_q[i] !== exp[i]) bad++;
        check_cnt++;
        if (bad != 0) $display("FAIL rand_beats: got %0d wrong beats want 0", bad);
        else pass_cnt++;
        check_cnt++;
        if (stall_err != 0) $display("FAIL rand_hold: got %0d violations want 0", stall_err);
        else pass_cnt++;
        ready_mode = 0;
    endtask

`ifdef SAKEBI_FCS_PAD_EN
    task automatic test_pad;
        byte_q_t kv = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                        8'h36, 8'h37, 8'h38, 8'h39};
        byte_q_t full;
        beat_q_t exp;
        ready_mode = 0;
        out_q.delete();
        exp = model(kv);
        send_frame(kv, 0, 1'b1);
        wait_out(64);
        check_cnt++;
        if (out_q.size() != 64) $display("FAIL pad9_len: got %0d want 64", out_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp.size(); i++) begin
            check_cnt++;
            if (i >= out_q.size() || out_q[i] !== exp[i])
                $display("FAIL pad9_beat[%0d]: got %h want %h", i,
                         (i < out_q.size()) ? out_q[i] : 9'hxxx, exp[i]);
            else pass_cnt++;
        end
        out_q.delete();
        full = rand_frame(MIN);
        exp  = model(full);
        send_frame(full, 20, 1'b1);
        wait_out(64);
        check_cnt++;
        if (out_q.size() != 64) $display("FAIL pad60_len: got %0d want 64", out_q.size());
        else pass_cnt++;
        for (int i = 0; i < exp.size(); i++) begin
            check_cnt++;
            if (i >= out_q.size() || out_q[i] !== exp[i])
                $display("FAIL pad60_beat[%0d]: got %h want %h", i,
                         (i < out_q.size()) ? out_q[i] : 9'hxxx, exp[i]);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = 8'h00;
        test_reset;
        test_known_vector;
        test_stall_toggle;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef SAKEBI_FCS_PAD_EN
        test_pad;
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
